rfid_fm0_tx: RTL and testbench

RFID_FM0_TX -- requirements
Module: rfid_fm0_tx

---
 rtl/rfid_fm0_tx.sv | 117 +++++++++++
 tb/tb_rfid_fm0_tx.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/rfid_fm0_tx.sv
// rtl/rfid_fm0_tx.sv - FM0 backscatter encoder: preamble, MSB-first payload, dummy data-1 end-of-signalling.
module rfid_fm0_tx #(
  parameter logic [11:0] PREAMBLE = 12'b110100100011
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic [127:0] data_in,
  input  logic [7:0]   bit_count,
  input  logic         tx_start,
  input  logic         blf_tick,
  output logic         tx_out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_EOS} state_t;

  state_t       state, state_nxt;
  logic [127:0] shreg, shreg_nxt;
  logic [7:0]   bits, bits_nxt;
  logic [7:0]   bit_idx, bit_idx_nxt;
  logic [3:0]   half, half_nxt;
  logic         tx_nxt, busy_nxt, done_nxt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      shreg   <= '0;
      bits    <= '0;
      bit_idx <= '0;
      half    <= '0;
      tx_out  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      bits    <= bits_nxt;
      bit_idx <= bit_idx_nxt;
      half    <= half_nxt;
      tx_out  <= tx_nxt;
      busy    <= busy_nxt;
      done    <= done_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    shreg_nxt   = shreg;
    bits_nxt    = bits;
    bit_idx_nxt = bit_idx;
    half_nxt    = half;
    tx_nxt      = tx_out;
    busy_nxt    = busy;
    done_nxt    = 1'b0;
    case (state)
      S_IDLE: begin
        tx_nxt   = 1'b0;
        busy_nxt = 1'b0;
        // A coincident blf_tick is deliberately not consumed here.
        if (tx_start) begin
          shreg_nxt   = data_in;
          bits_nxt    = (bit_count > 8'd128) ? 8'd128 : bit_count;
          bit_idx_nxt = '0;
          half_nxt    = '0;
          busy_nxt    = 1'b1;
          state_nxt   = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (blf_tick) begin
          tx_nxt = PREAMBLE[4'd11 - half];
          if (half == 4'd11) begin
            half_nxt  = '0;
            state_nxt = (bits == 8'd0) ? S_EOS : S_DATA;
          end else begin
            half_nxt = half + 4'd1;
          end
        end
      end
      S_DATA: begin
        if (blf_tick) begin
          if (!half[0]) begin
            tx_nxt   = ~tx_out;
            half_nxt = 4'd1;
          end else begin
            // Second half repeats the first for a 1 and inverts it for a 0.
            tx_nxt      = shreg[127] ? tx_out : ~tx_out;
            half_nxt    = '0;
            shreg_nxt   = {shreg[126:0], 1'b0};
            bit_idx_nxt = bit_idx + 8'd1;
            if (bit_idx_nxt == bits) state_nxt = S_EOS;
          end
        end
      end
      S_EOS: begin
        if (blf_tick) begin
          if (half == 4'd0) begin
            tx_nxt   = ~tx_out;
            half_nxt = 4'd1;
          end else if (half == 4'd1) begin
            half_nxt = 4'd2;
          end else begin
            tx_nxt      = 1'b0;
            busy_nxt    = 1'b0;
            done_nxt    = 1'b1;
            half_nxt    = '0;
            bit_idx_nxt = '0;
            state_nxt   = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rfid_fm0_tx.sv
// tb/tb_rfid_fm0_tx.sv - directed bench for rfid_fm0_tx with hand-computed FM0 waveforms.
module tb_rfid_fm0_tx;

  logic         clock = 1'b0;
  logic         reset_n = 1'b0;
  logic [127:0] data_in = '0;
  logic [7:0]   bit_count = '0;
  logic         tx_start = 1'b0;
  logic         blf_tick = 1'b0;
  logic         tx_out, busy, done;

  int vecs = 0;
  int errs = 0;
  logic [0:299] e;

  rfid_fm0_tx dut (
    .clock(clock), .reset_n(reset_n), .data_in(data_in), .bit_count(bit_count),
    .tx_start(tx_start), .blf_tick(blf_tick), .tx_out(tx_out), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic t);
    blf_tick = t;
    @(posedge clock);
    #1;
    blf_tick = 1'b0;
  endtask

  task automatic start(input logic [127:0] d, input logic [7:0] n, input logic t);
    tx_start = 1'b1; data_in = d; bit_count = n; blf_tick = t;
    @(posedge clock);
    #1;
    tx_start = 1'b0; blf_tick = 1'b0;
    chk("start_busy", {7'd0, busy}, 8'd1);
    chk("start_tx", {7'd0, tx_out}, 8'd0);
    chk("start_done", {7'd0, done}, 8'd0);
  endtask

  task automatic tk(input string tag, input logic lvl);
    cyc(1'b1);
    chk(tag, {7'd0, tx_out}, {7'd0, lvl});
    chk("busy_high", {7'd0, busy}, 8'd1);
    chk("no_done", {7'd0, done}, 8'd0);
  endtask

  task automatic gap(input int n, input logic lvl);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0);
      chk("gap_hold", {7'd0, tx_out}, {7'd0, lvl});
    end
  endtask

  task automatic play(input logic [0:299] x, input int first, input int last, input logic fin);
    for (int k = first; k < last; k++) tk("level", x[k]);
    if (fin) begin
      cyc(1'b1);
      chk("end_done", {7'd0, done}, 8'd1);
      chk("end_busy", {7'd0, busy}, 8'd0);
      chk("end_tx", {7'd0, tx_out}, 8'd0);
    end
  endtask

  task automatic idle_chk;
    cyc(1'b0);
    chk("idle_done", {7'd0, done}, 8'd0);
    chk("idle_busy", {7'd0, busy}, 8'd0);
    chk("idle_tx", {7'd0, tx_out}, 8'd0);
  endtask

  initial begin
    repeat (3) @(posedge clock);
    #1;
    chk("rst_tx", {7'd0, tx_out}, 8'd0);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    reset_n = 1'b1;
    // Ticks while idle are ignored.
    repeat (3) begin
      cyc(1'b1);
      chk("idle_tick_tx", {7'd0, tx_out}, 8'd0);
      chk("idle_tick_busy", {7'd0, busy}, 8'd0);
    end

    // Two bits 1,0.
    e = '0;
    e[0:17] = 18'b110100100011_001011;
    start({2'b10, 126'd0}, 8'd2, 1'b0);
    play(e, 0, 18, 1'b1);
    idle_chk();

    // Zero bits: preamble then dummy 0,0; new start accepted in the done cycle.
    e = '0;
    e[0:13] = 14'b110100100011_00;
    start({128{1'b1}}, 8'd0, 1'b0);
    play(e, 0, 14, 1'b1);
    e = '0;
    e[0:17] = 18'b110100100011_001011;
    start({2'b10, 126'd0}, 8'd2, 1'b0);
    play(e, 0, 18, 1'b1);
    idle_chk();

    // bit_count=200 clamps to 128; all ones alternate every 2 ticks.
    e = '0;
    e[0:11] = 12'b110100100011;
    for (int j = 0; j < 256; j++) e[12 + j] = j[1];
    e[268] = 1'b0;
    e[269] = 1'b0;
    start({128{1'b1}}, 8'd200, 1'b0);
    play(e, 0, 270, 1'b1);
    idle_chk();

    // Restart attempt during DATA is ignored.
    e = '0;
    e[0:21] = 22'b110100100011_01001101_00;
    start({4'b0110, 124'd0}, 8'd4, 1'b0);
    play(e, 0, 14, 1'b0);
    tx_start = 1'b1; data_in = {128{1'b1}}; bit_count = 8'd128;
    cyc(1'b0);
    tx_start = 1'b0;
    play(e, 14, 22, 1'b1);
    idle_chk();

    // Async reset at tick 20 of a 16-bit frame.
    e = '0;
    e[0:11] = 12'b110100100011;
    for (int j = 0; j < 32; j++) e[12 + j] = j[1];
    start({128{1'b1}}, 8'd16, 1'b0);
    play(e, 0, 19, 1'b0);
    #2 reset_n = 1'b0;
    #1;
    chk("async_rst_tx", {7'd0, tx_out}, 8'd0);
    chk("async_rst_busy", {7'd0, busy}, 8'd0);
    cyc(1'b1);
    reset_n = 1'b1;
    repeat (20) begin
      cyc(1'b1);
      chk("post_rst_done", {7'd0, done}, 8'd0);
      chk("post_rst_busy", {7'd0, busy}, 8'd0);
      chk("post_rst_tx", {7'd0, tx_out}, 8'd0);
    end
    e = '0;
    e[0:17] = 18'b110100100011_001011;
    start({2'b10, 126'd0}, 8'd2, 1'b0);
    play(e, 0, 18, 1'b1);
    idle_chk();

    // tx_start with coincident tick, then irregular tick gaps.
    start({2'b10, 126'd0}, 8'd2, 1'b1);
    gap(1, 1'b0);
    tk("gap_tick1", e[0]);
    gap(3, e[0]);
    tk("gap_tick2", e[1]);
    gap(7, e[1]);
    play(e, 2, 18, 1'b1);
    idle_chk();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
